sar_scan: RTL and testbench
===========================

Name: sar_scan

Overview:
Parametrised multi-channel SAR ADC controller; successor to the single-channel 8-bit SAR controller.
- Scans an enabled subset of analog channels through the external input mux.
- Applies a programmable settle time per sample and per bit trial.
- Delivers tagged results over a valid/ready handshake, with overrun detection and a one-shot or continuous scan mode.
- Sits between the comparator/capacitive DAC front end and the digital readout logic.

Parameters:
RESOLUTION, 8, conversion width in bits (>=2)
CHANNELS, 4, number of analog input channels (>=1)
SETTLE_W, 4, width of the settle-count input
AVG_LOG2, 2, log2 of samples averaged per channel (used only with SAR_SCAN_AVG_EN)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  start scan (level-sampled; ignored while busy)
cont_i  in  1  continuous mode; sampled at start
ch_en_i  in  CHANNELS  channel enable mask; latched at start
settle_i  in  SETTLE_W  extra settle cycles S; latched at start
comp_i  in  1  comparator: 1 = input >= DAC
dac_o  out  RESOLUTION  DAC trial code
ch_sel_o  out  $clog2(CHANNELS) (min 1)  analog mux select
sample_o  out  1  sample switch closed
busy_o  out  1  scan in progress
valid_o  out  1  result available
ready_i  in  1  consumer accepts result
data_o  out  RESOLUTION  result
ch_o  out  $clog2(CHANNELS) (min 1)  channel tag of data_o
overrun_o  out  1  one-cycle pulse: unread result overwritten

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latched config cleared.
- States: IDLE, SAMPLE, CONVERT, STORE.
- IDLE:
  - start_i=1 and ch_en_i!=0: latch ch_en_i, settle_i, cont_i; select the lowest enabled channel; go to SAMPLE.
  - start_i=1 with ch_en_i=0: no effect; stay in IDLE.
- SAMPLE: sample_o=1, dac_o=0, ch_sel_o=current channel for S+1 cycles, then go to CONVERT with mask=MSB and dac=MSB.
- CONVERT:
  - Each bit trial lasts S+1 cycles; comp_i is evaluated only on the last cycle of the trial.
  - comp_i=1 keeps the bit; comp_i=0 clears it.
  - The next trial sets mask>>1 on top of the kept bits.
  - After the LSB decision, go to STORE.
- STORE (1 cycle):
  - Load data_o/ch_o and set valid_o.
  - If valid_o=1 and ready_i=0 in this cycle, overwrite anyway and pulse overrun_o.
  - Then advance to the next enabled channel above the current one.
  - Wrap past the highest enabled channel: cont_i latched=1 resumes at the lowest enabled channel; otherwise go to IDLE.
- Timing: valid_o rises exactly 1+(S+1)(RESOLUTION+1) cycles after the start edge, for the first channel of a scan.
- busy_o=1 in every state except IDLE; dac_o=0 in IDLE and STORE.
- Handshake: valid_o clears on the cycle after valid_o&&ready_i, unless STORE writes that same cycle, in which case valid_o stays 1 with no overrun.
- start_i, ch_en_i and settle_i changes during a scan are ignored.
- Stopping continuous mode requires reset.
- Reset mid-conversion aborts immediately; no partial result is emitted.
- S=0 gives one cycle per trial.

Optional Feature:
Macro SAR_SCAN_AVG_EN.
- Defined:
  - Each channel runs 2^AVG_LOG2 consecutive SAMPLE+CONVERT passes.
  - Results accumulate in a RESOLUTION+AVG_LOG2 bit accumulator, cleared per channel.
  - STORE is entered once per channel; data_o = accumulator >> AVG_LOG2 (truncating).
- Undefined: one pass per channel; AVG_LOG2 is unused and no accumulator exists.

Decomposition:
- Package sar_pkg:
  - sar_state_t enum (IDLE, SAMPLE, CONVERT, STORE).
  - CH_W localparam function (max(1,$clog2(n))).
- Sub-module sar_next_ch: combinational search over the latched mask from the current index.
  - Returns the next enabled channel and a wrap flag.
  - Parametrised by CHANNELS.

Test Plan:
Common setup: RESOLUTION=8, CHANNELS=4, comparator model comp_i=(vin[ch_sel_o] >= dac_o).
1. Single scan, S=0, ch_en=4'b0101, vin0=0xA5, vin2=0x3C, ready_i=1:
   - First valid_o exactly 10 cycles after start, with ch_o=0, data_o=0xA5.
   - Then ch_o=2, data_o=0x3C.
   - busy_o falls; no further outputs.
2. S=3, ch_en=4'b1000, vin3=0xFF -> data_o=0xFF, ch_o=3, first valid_o 37 cycles after start; sample_o high 4 cycles.
3. Continuous mode, ch_en=4'b0011, ready_i held 0 -> second STORE pulses overrun_o, data_o shows the latest value; channel order 0,1,0,1...
4. start_i with ch_en_i=0 -> busy_o stays 0. Assert rst_ni low mid-CONVERT -> all outputs 0 immediately; valid_o never rises.
5. Boundary codes: vin=0x00 -> 0x00; vin=0x80 -> 0x80; vin=0x7F -> 0x7F.
6. SAR_SCAN_AVG_EN, AVG_LOG2=2, comparator input sequence 10,11,12,13 on ch1 -> single valid_o, data_o=11, ch_o=1.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and helpers for the multi-channel SAR scan controller.
package sar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StConvert,
    StStore
  } sar_state_t;

  // Index width for n channels, never below one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_next_ch.sv
// Finds the next enabled channel above cur_i; wraps to the lowest enabled channel otherwise.
module sar_next_ch
  import sar_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned CW = ch_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] mask_i,
  input  logic [CW-1:0]       cur_i,
  output logic [CW-1:0]       next_o,
  output logic                wrap_o
);

  always_comb begin
    next_o = '0;
    wrap_o = 1'b1;
    // Descending scans leave the lowest qualifying index as the final assignment.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask_i[i]) next_o = CW'(i);
    end
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(cur_i))) begin
        next_o = CW'(i);
        wrap_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sar_scan.sv
// Multi-channel SAR ADC scan controller with tagged valid/ready results.
// Optional per-channel averaging is enabled by defining SAR_SCAN_AVG_EN.
module sar_scan
  import sar_pkg::*;
#(
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned SETTLE_W   = 4,
  parameter int unsigned AVG_LOG2   = 2,
  localparam int unsigned CH_W = ch_w(CHANNELS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  cont_i,
  input  logic [CHANNELS-1:0]   ch_en_i,
  input  logic [SETTLE_W-1:0]   settle_i,
  input  logic                  comp_i,
  output logic [RESOLUTION-1:0] dac_o,
  output logic [CH_W-1:0]       ch_sel_o,
  output logic                  sample_o,
  output logic                  busy_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [RESOLUTION-1:0] data_o,
  output logic [CH_W-1:0]       ch_o,
  output logic                  overrun_o
);

  localparam logic [RESOLUTION-1:0] Msb = {1'b1, {(RESOLUTION - 1){1'b0}}};

  sar_state_t            state_q;
  logic [CHANNELS-1:0]   mask_q;
  logic [SETTLE_W-1:0]   settle_q;
  logic                  cont_q;
  logic [SETTLE_W-1:0]   cnt_q;
  logic [RESOLUTION-1:0] bit_q;
  logic [RESOLUTION-1:0] dac_q;
  logic [RESOLUTION-1:0] res_q;
  logic [CH_W-1:0]       ch_q;
  logic [RESOLUTION-1:0] data_q;
  logic [CH_W-1:0]       tag_q;
  logic                  valid_q;
  logic                  overrun_q;
  logic                  sample_q;

  logic [RESOLUTION-1:0] trial;
  logic [CHANNELS-1:0]   srch_mask;
  logic [CH_W-1:0]       srch_cur;
  logic [CH_W-1:0]       nxt_ch;
  logic                  nxt_wrap;
  logic                  settled;

  // Bit decision for the current trial: keep the trial bit only if input >= DAC.
  assign trial   = comp_i ? dac_q : (dac_q & ~bit_q);
  assign settled = (cnt_q == settle_q);

  // In idle the search starts above the top index, yielding the lowest enabled channel.
  assign srch_mask = (state_q == StIdle) ? ch_en_i : mask_q;
  assign srch_cur  = (state_q == StIdle) ? CH_W'(CHANNELS - 1) : ch_q;

  sar_next_ch #(
    .CHANNELS(CHANNELS)
  ) u_next_ch (
    .mask_i(srch_mask),
    .cur_i (srch_cur),
    .next_o(nxt_ch),
    .wrap_o(nxt_wrap)
  );

`ifdef SAR_SCAN_AVG_EN
  localparam int unsigned AccW = RESOLUTION + AVG_LOG2;
  localparam int unsigned PassW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [PassW-1:0] LastPass = PassW'((1 << AVG_LOG2) - 1);

  logic [AccW-1:0]  acc_q;
  logic [PassW-1:0] pass_q;
  logic [AccW-1:0]  acc_sum;

  assign acc_sum = acc_q + AccW'(trial);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      settle_q  <= '0;
      cont_q    <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      dac_q     <= '0;
      res_q     <= '0;
      ch_q      <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      sample_q  <= 1'b0;
`ifdef SAR_SCAN_AVG_EN
      acc_q     <= '0;
      pass_q    <= '0;
`endif
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && ready_i) valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start_i && (|ch_en_i)) begin
            mask_q   <= ch_en_i;
            settle_q <= settle_i;
            cont_q   <= cont_i;
            ch_q     <= nxt_ch;
            cnt_q    <= '0;
            sample_q <= 1'b1;
            state_q  <= StSample;
          end
        end

        StSample: begin
          if (settled) begin
            cnt_q    <= '0;
            sample_q <= 1'b0;
            bit_q    <= Msb;
            dac_q    <= Msb;
            state_q  <= StConvert;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StConvert: begin
          if (!settled) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (!bit_q[0]) begin
            cnt_q <= '0;
            bit_q <= bit_q >> 1;
            dac_q <= trial | (bit_q >> 1);
          end else begin
            cnt_q <= '0;
            dac_q <= '0;
`ifdef SAR_SCAN_AVG_EN
            if (pass_q == LastPass) begin
              res_q   <= RESOLUTION'(acc_sum >> AVG_LOG2);
              acc_q   <= '0;
              pass_q  <= '0;
              state_q <= StStore;
            end else begin
              acc_q    <= acc_sum;
              pass_q   <= pass_q + 1'b1;
              sample_q <= 1'b1;
              state_q  <= StSample;
            end
`else
            res_q   <= trial;
            state_q <= StStore;
`endif
          end
        end

        StStore: begin
          data_q  <= res_q;
          tag_q   <= ch_q;
          valid_q <= 1'b1;
          // A simultaneous accept consumes the old result, so only an unread one overruns.
          if (valid_q && !ready_i) overrun_q <= 1'b1;
          if (nxt_wrap && !cont_q) begin
            ch_q    <= '0;
            state_q <= StIdle;
          end else begin
            ch_q     <= nxt_ch;
            cnt_q    <= '0;
            sample_q <= 1'b1;
            state_q  <= StSample;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign dac_o     = dac_q;
  assign ch_sel_o  = ch_q;
  assign sample_o  = sample_q;
  assign busy_o    = (state_q != StIdle);
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign ch_o      = tag_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_sar_scan.sv
// Directed self-checking bench for sar_scan with an ideal-comparator front-end model.
module tb_sar_scan;

  localparam int unsigned RES = 8;
  localparam int unsigned CH  = 4;
  localparam int unsigned SW  = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          cont_i = 1'b0;
  logic [CH-1:0] ch_en_i = '0;
  logic [SW-1:0] settle_i = '0;
  logic          comp_i;
  logic [RES-1:0] dac_o;
  logic [1:0]    ch_sel_o;
  logic          sample_o;
  logic          busy_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [RES-1:0] data_o;
  logic [1:0]    ch_o;
  logic          overrun_o;

  logic [7:0] vin [CH];

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
  } res_t;

  res_t exp_q[$];
  res_t exp_r;

  always #5 clk_i = ~clk_i;

  // Ideal comparator on the currently selected analog input.
  assign comp_i = (vin[ch_sel_o] >= dac_o);

  sar_scan #(
    .RESOLUTION(RES),
    .CHANNELS  (CH),
    .SETTLE_W  (SW),
    .AVG_LOG2  (2)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .cont_i   (cont_i),
    .ch_en_i  (ch_en_i),
    .settle_i (settle_i),
    .comp_i   (comp_i),
    .dac_o    (dac_o),
    .ch_sel_o (ch_sel_o),
    .sample_o (sample_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .ch_o     (ch_o),
    .overrun_o(overrun_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // An exact input code converts to itself; results appear in ascending channel order.
  task automatic expect_scan(input logic [CH-1:0] m);
    for (int i = 0; i < CH; i++) begin
      if (m[i]) exp_q.push_back({2'(i), vin[i]});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_dac"}, dac_o, 0);
    check({tag, "_sample"}, sample_o, 0);
    check({tag, "_chsel"}, ch_sel_o, 0);
    check({tag, "_data"}, data_o, 0);
    check({tag, "_ch"}, ch_o, 0);
    check({tag, "_ovr"}, overrun_o, 0);
  endtask

  // Start a scan and measure cycles from the start edge to the first valid_o.
  task automatic run_scan(input logic [CH-1:0] m, input logic [SW-1:0] s, input logic c,
                          output int lat, output int samp);
    @(negedge clk_i);
    ch_en_i  = m;
    settle_i = s;
    cont_i   = c;
    start_i  = 1'b1;
    @(posedge clk_i);
    #1;
    start_i  = 1'b0;
    ch_en_i  = ~m;
    settle_i = ~s;
    lat  = 0;
    samp = sample_o ? 1 : 0;
    while (!valid_o && lat < 2000) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (sample_o) samp++;
    end
    if (!valid_o) check("valid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_i);
    while (busy_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("busy_timeout", busy_o, 0);
    repeat (20) @(negedge clk_i);
    check("drained", exp_q.size(), 0);
  endtask

  // Compare process: result scoreboard plus idle/sample invariants every cycle.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (!busy_o) begin
        check("idle_dac", dac_o, 0);
        check("idle_sample", sample_o, 0);
      end
      if (sample_o) check("sample_dac", dac_o, 0);
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_r = exp_q.pop_front();
          check("ch_o", ch_o, exp_r.ch);
          check("data_o", data_o, exp_r.data);
        end
      end
    end
  end

`ifdef SAR_SCAN_AVG_EN
  logic       avg_on = 1'b0;
  int         avg_n = 0;
  logic [7:0] avg_seq [4] = '{8'd10, 8'd11, 8'd12, 8'd13};

  // Present a new input value at the start of every sampling pass.
  always @(posedge sample_o) begin
    if (avg_on && avg_n < 4) begin
      vin[1] = avg_seq[avg_n];
      avg_n++;
    end
  end
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int samp;
    int got;
    logic [1:0] ech;

    for (int i = 0; i < CH; i++) vin[i] = 8'h00;

    // Reset state
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Two-channel single scan, S=0
    vin[0] = 8'hA5; vin[1] = 8'h11; vin[2] = 8'h3C; vin[3] = 8'hEE;
    expect_scan(4'b0101);
    run_scan(4'b0101, 4'd0, 1'b0, lat, samp);
    check("t1_latency", lat, 10);
    check("t1_first_ch", ch_o, 0);
    check("t1_first_data", data_o, 8'hA5);
    wait_idle();

    // Long settle, top channel, full-scale code
    vin[3] = 8'hFF;
    expect_scan(4'b1000);
    run_scan(4'b1000, 4'd3, 1'b0, lat, samp);
    check("t2_latency", lat, 37);
    check("t2_sample_cycles", samp, 4);
    check("t2_data", data_o, 8'hFF);
    check("t2_ch", ch_o, 3);
    wait_idle();

    // Boundary codes
    vin[0] = 8'h00; vin[1] = 8'h80; vin[2] = 8'h7F;
    expect_scan(4'b0111);
    run_scan(4'b0111, 4'd1, 1'b0, lat, samp);
    check("t5_latency", lat, 19);
    wait_idle();

    // Continuous mode with a stalled consumer
    ready_i = 1'b0;
    vin[0] = 8'h5A; vin[1] = 8'hC3;
    run_scan(4'b0011, 4'd0, 1'b1, lat, samp);
    check("t3_latency", lat, 10);
    check("t3_first_ch", ch_o, 0);
    check("t3_first_data", data_o, 8'h5A);
    got = 0;
    for (int n = 0; n < 200 && got < 3; n++) begin
      @(negedge clk_i);
      if (overrun_o) begin
        ech = (got % 2 == 0) ? 2'd1 : 2'd0;
        check("t3_ovr_ch", ch_o, ech);
        check("t3_ovr_data", data_o, vin[ech]);
        check("t3_ovr_valid", valid_o, 1);
        got++;
      end
    end
    check("t3_overruns", got, 3);
    check("t3_still_busy", busy_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_all_zero("t3_reset");
    @(negedge clk_i);
    ready_i = 1'b1;
    rst_ni  = 1'b1;

    // Start with an empty mask does nothing
    @(negedge clk_i);
    ch_en_i = 4'b0000;
    start_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      check("t4_empty_busy", busy_o, 0);
    end
    start_i = 1'b0;

    // Reset in the middle of a conversion
    vin[0] = 8'h42;
    @(negedge clk_i);
    ch_en_i  = 4'b0001;
    settle_i = 4'd3;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("t4_mid_busy", busy_o, 1);
    check("t4_mid_sample", sample_o, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("t4_abort");
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (60) @(negedge clk_i);
    check("t4_no_valid", valid_o, 0);
    check("t4_idle", busy_o, 0);

`ifdef SAR_SCAN_AVG_EN
    // Four averaged passes of 10,11,12,13 truncate to 11
    avg_n  = 0;
    avg_on = 1'b1;
    exp_q.push_back({2'd1, 8'd11});
    run_scan(4'b0010, 4'd0, 1'b0, lat, samp);
    check("avg_latency", lat, 37);
    check("avg_data", data_o, 11);
    check("avg_ch", ch_o, 1);
    wait_idle();
    avg_on = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
